scard_char_tx: RTL and testbench
================================

Name: scard_char_tx

Overview:
- Parametrised ISO 7816-3 character transmitter for the smartcard I/O line.
- Successor to the fixed-rate smartcard TX.
- Adds:
  - runtime ETU divisor
  - selectable data width and parity mode
  - programmable extra guard time
  - T=0 error-signal detection with automatic bounded retransmission
- Sits between the smartcard protocol FSM (byte handshake) and the open-drain I/O pad driver.

Parameters:
- DATA_BITS, 8, character data bits (5..8).
- ETU_WIDTH, 16, width of ETU divisor (clocks per ETU).
- GUARD_WIDTH, 8, width of extra-guard-time count (ETUs).
- RETRY_WIDTH, 3, width of retry limit/counter.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  reset, asynchronous, active-low.
- etu_div  in  ETU_WIDTH  clocks per ETU, legal >= 4; latched on accept.
- parity_mode  in  2  00 even, 01 odd, 10 none, 11 reserved (treated as even); latched on accept.
- guard_etu  in  GUARD_WIDTH  extra ETUs appended after the 2 mandatory guard ETUs; latched on accept.
- retry_en  in  1  enable T=0 error-signal retransmit; latched on accept.
- retry_max  in  RETRY_WIDTH  maximum retransmissions; latched on accept.
- tx_start  in  1  request; accepted only when tx_ready=1.
- tx_data  in  DATA_BITS  character, LSB first on line; latched on accept.
- tx_ready  out  1  high in IDLE only.
- io_in  in  1  synchronised I/O line readback, for error-signal detection.
- txd  out  1  registered line drive; 1 = released/high.
- tx_done  out  1  1-cycle pulse: character delivered without error.
- tx_err  out  1  1-cycle pulse: retries exhausted, character abandoned.
- retry_cnt  out  RETRY_WIDTH  retransmissions used for current/last character.

Behaviour:
- Reset (async assert, sync release):
  - state IDLE, txd=1, tx_ready=1, tx_done=0, tx_err=0, retry_cnt=0.
  - ETU counter cleared.
  - Reset mid-character: immediate release (txd=1); no done/err pulse.
- ETU timing:
  - Down-counter loaded with etu_div_q-1 on every ETU boundary.
  - etu_tick when counter=0.
  - etu_mid when counter = etu_div_q>>1.
  - Counter runs only outside IDLE; each ETU is exactly etu_div_q clocks.
- Accept: tx_start && tx_ready in cycle N → all config and data latched, retry_cnt cleared, txd=0 from cycle N+1. tx_start while busy is ignored.
- Frame (ETU index): START(0, low) → DATA(1..DATA_BITS) → PARITY(1 ETU; skipped when mode=none) → GUARD1 → GUARD2 → XGUARD (guard_etu ETUs, skipped if 0) → DONE.
- Parity bit:
  - even: XOR of data.
  - odd: inverted XOR.
- Guard ETUs: txd=1 through GUARD1, GUARD2 and XGUARD.
- Error window:
  - io_in sampled at etu_mid of GUARD2 only, i.e. 1.5 ETU after parity end.
  - Sampling qualifies only if retry_en=1 and parity_mode != none.
- Error seen (io_in=0):
  - retry_cnt < retry_max: retry_cnt++, enter RECOVER.
  - Otherwise: tx_err pulse, return to IDLE.
- RECOVER:
  - Wait until io_in=1 at an etu_tick, then 2 further ETUs high, then restart at START with the same latched data.
  - io_in stuck low keeps the block in RECOVER indefinitely; only reset exits.
- DONE: tx_done pulse for 1 cycle, then IDLE on the next cycle (tx_ready=1).
  - tx_done and tx_err are mutually exclusive.
  - tx_start in the DONE cycle is ignored.
- Frame length without error: (1 + DATA_BITS + P + 2 + guard_etu) × etu_div clocks, where P = 0/1 for parity none/other; plus 1 DONE cycle.
- retry_max=0 with retry_en=1: first error → tx_err immediately.
- Width rules:
  - ETU counter is ETU_WIDTH bits.
  - Guard counter is GUARD_WIDTH bits.
  - retry_cnt saturates at retry_max, never wraps.

Decomposition:
- Package scard_pkg holds:
  - parity mode constants (PAR_EVEN, PAR_ODD, PAR_NONE)
  - the TX state encoding (IDLE, START, DATA, PARITY, GUARD1, GUARD2, XGUARD, RECOVER, DONE)
  - minimum ETU constant (4)
- Sub-module scard_etu_gen, reused by the future receiver:
  - inputs: load, etu_div
  - outputs: etu_tick, etu_mid

Test Plan:
- etu_div=372, data=0x3B, even parity, guard_etu=0 → line low 372 clocks, bits 1,1,0,1,1,1,0,0, parity 1, 744 clocks high; tx_done at 12×372+1 cycles after accept.
- etu_div=4, parity odd, DATA_BITS=8, data=0x00 → parity bit 1. Parity none with data=0xFF → frame 11 ETU, no parity ETU.
- retry_en=1, retry_max=2, io_in forced low for 2 ETU at GUARD2 mid on every attempt → 3 transmissions, retry_cnt=2, one tx_err pulse, no tx_done.
- Same as above but error on the first attempt only → second frame starts 2 ETU after io_in high, tx_done, retry_cnt=1.
- tx_start held high through frame, new tx_data mid-frame → second character starts only after IDLE; first character's bits unchanged.
- rst_n asserted at DATA bit 3 → txd=1 asynchronously. After release, tx_ready=1 and a new 0xA5 frame transmits correctly.

Source files
------------

// File: rtl/scard_pkg.sv
// Shared definitions for the smartcard character path: parity modes,
// transmitter state encoding and the parity helper.
package scard_pkg;

  localparam logic [1:0] PAR_EVEN = 2'b00;
  localparam logic [1:0] PAR_ODD  = 2'b01;
  localparam logic [1:0] PAR_NONE = 2'b10;

  // Smallest ETU divisor that still leaves a distinct mid-ETU sample point.
  localparam int ETU_MIN = 4;

  typedef enum logic [3:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    GUARD1,
    GUARD2,
    XGUARD,
    RECOVER,
    DONE
  } tx_state_e;

  // Parity over a zero-extended character; reserved mode 11 behaves as even.
  function automatic logic calc_parity(input logic [7:0] data, input logic [1:0] mode);
    calc_parity = (^data) ^ (mode == PAR_ODD);
  endfunction

endpackage

// File: rtl/scard_etu_gen.sv
// ETU timebase: down-counter reloaded with etu_div-1 on every ETU boundary,
// producing an end-of-ETU tick and a mid-ETU strobe for line sampling.
module scard_etu_gen #(
  parameter int ETU_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_en,
  input  logic                 i_load,
  input  logic [ETU_WIDTH-1:0] i_etu_div,
  output logic                 o_etu_tick,
  output logic                 o_etu_mid
);

  logic [ETU_WIDTH-1:0] r_cnt;
  logic [ETU_WIDTH-1:0] w_reload;

  assign w_reload   = i_etu_div - ETU_WIDTH'(1);
  assign o_etu_tick = i_en && (r_cnt == '0);
  assign o_etu_mid  = i_en && (r_cnt == (i_etu_div >> 1));

  // Load at frame start, wrap on every tick, otherwise count down while enabled
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load || o_etu_tick) begin
      r_cnt <= w_reload;
    end else if (i_en) begin
      r_cnt <= r_cnt - ETU_WIDTH'(1);
    end
  end

endmodule

// File: rtl/scard_char_tx.sv
// ISO 7816-3 character transmitter: start/data/parity/guard framing with
// runtime ETU, optional extra guard time and T=0 error-signal retransmission.
module scard_char_tx
  import scard_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int ETU_WIDTH   = 16,
  parameter int GUARD_WIDTH = 8,
  parameter int RETRY_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [ETU_WIDTH-1:0]   i_etu_div,
  input  logic [1:0]             i_parity_mode,
  input  logic [GUARD_WIDTH-1:0] i_guard_etu,
  input  logic                   i_retry_en,
  input  logic [RETRY_WIDTH-1:0] i_retry_max,
  input  logic                   i_tx_start,
  input  logic [DATA_BITS-1:0]   i_tx_data,
  output logic                   o_tx_ready,
  input  logic                   i_io_in,
  output logic                   o_txd,
  output logic                   o_tx_done,
  output logic                   o_tx_err,
  output logic [RETRY_WIDTH-1:0] o_retry_cnt
);

  // Bit index only ever needs to address up to 8 data bits.
  localparam int BIT_W = 3;

  logic [1:0]             r_rst_sync;
  logic                   w_rst_n;

  tx_state_e              r_state, w_state_next;
  logic [DATA_BITS-1:0]   r_data;
  logic [1:0]             r_par_mode;
  logic [GUARD_WIDTH-1:0] r_guard, r_guard_cnt, w_guard_cnt_next;
  logic                   r_retry_en;
  logic [RETRY_WIDTH-1:0] r_retry_max, r_retry_cnt;
  logic [ETU_WIDTH-1:0]   r_etu_div, w_etu_div;
  logic [BIT_W-1:0]       r_bit_idx, w_bit_idx_next;
  logic [1:0]             r_rec_cnt, w_rec_cnt_next;
  logic                   r_txd, w_txd_next;
  logic                   r_err, w_err_next;
  logic                   w_retry_inc, w_accept, w_etu_en;
  logic                   w_etu_tick, w_etu_mid;
  logic                   w_par, w_last_bit, w_err_seen;

  // Reset asserts immediately, releases two clocks later on a clean edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_rst_sync <= 2'b00;
    else        r_rst_sync <= {r_rst_sync[0], 1'b1};
  end
  assign w_rst_n = r_rst_sync[1];

  assign w_accept   = (r_state == IDLE) && i_tx_start;
  assign w_etu_div  = w_accept ? i_etu_div : r_etu_div;
  assign w_etu_en   = (r_state != IDLE);
  assign w_par      = calc_parity(8'(r_data), r_par_mode);
  assign w_last_bit = (r_bit_idx == BIT_W'(DATA_BITS - 1));
  // Card error signal only counts when retransmission is meaningful
  assign w_err_seen = w_etu_mid && r_retry_en && (r_par_mode != PAR_NONE) && !i_io_in;

  scard_etu_gen #(
    .ETU_WIDTH (ETU_WIDTH)
  ) u_etu (
    .clk        (clk),
    .rst_n      (w_rst_n),
    .i_en       (w_etu_en),
    .i_load     (w_accept),
    .i_etu_div  (w_etu_div),
    .o_etu_tick (w_etu_tick),
    .o_etu_mid  (w_etu_mid)
  );

  // Next-state, frame counters and next line level
  always_comb begin
    w_state_next     = r_state;
    w_bit_idx_next   = r_bit_idx;
    w_guard_cnt_next = r_guard_cnt;
    w_rec_cnt_next   = r_rec_cnt;
    w_retry_inc      = 1'b0;
    w_err_next       = 1'b0;
    w_txd_next       = 1'b1;

    case (r_state)
      IDLE: begin
        if (i_tx_start) w_state_next = START;
      end
      START: begin
        if (w_etu_tick) begin
          w_state_next   = DATA;
          w_bit_idx_next = '0;
        end
      end
      DATA: begin
        if (w_etu_tick) begin
          if (w_last_bit) w_state_next = (r_par_mode == PAR_NONE) ? GUARD1 : PARITY;
          else            w_bit_idx_next = r_bit_idx + BIT_W'(1);
        end
      end
      PARITY: begin
        if (w_etu_tick) w_state_next = GUARD1;
      end
      GUARD1: begin
        if (w_etu_tick) w_state_next = GUARD2;
      end
      GUARD2: begin
        if (w_err_seen) begin
          if (r_retry_cnt < r_retry_max) begin
            w_state_next   = RECOVER;
            w_retry_inc    = 1'b1;
            w_rec_cnt_next = 2'd0;
          end else begin
            w_state_next = IDLE;
            w_err_next   = 1'b1;
          end
        end else if (w_etu_tick) begin
          if (r_guard == '0) begin
            w_state_next = DONE;
          end else begin
            w_state_next     = XGUARD;
            w_guard_cnt_next = '0;
          end
        end
      end
      XGUARD: begin
        if (w_etu_tick) begin
          if (r_guard_cnt == r_guard - GUARD_WIDTH'(1)) w_state_next = DONE;
          else w_guard_cnt_next = r_guard_cnt + GUARD_WIDTH'(1);
        end
      end
      RECOVER: begin
        if (w_etu_tick) begin
          case (r_rec_cnt)
            2'd0:    if (i_io_in) w_rec_cnt_next = 2'd1;
            2'd1:    w_rec_cnt_next = 2'd2;
            default: w_state_next = START;
          endcase
        end
      end
      DONE: begin
        w_state_next = IDLE;
      end
      default: begin
        w_state_next = IDLE;
      end
    endcase

    case (w_state_next)
      START:   w_txd_next = 1'b0;
      DATA:    w_txd_next = r_data[w_bit_idx_next];
      PARITY:  w_txd_next = w_par;
      default: w_txd_next = 1'b1;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) r_state <= IDLE;
    else          r_state <= w_state_next;
  end

  // Line drive, counters and per-character configuration latch
  always_ff @(posedge clk or negedge w_rst_n) begin
    if (!w_rst_n) begin
      r_txd       <= 1'b1;
      r_err       <= 1'b0;
      r_bit_idx   <= '0;
      r_guard_cnt <= '0;
      r_rec_cnt   <= '0;
      r_data      <= '0;
      r_par_mode  <= PAR_EVEN;
      r_guard     <= '0;
      r_retry_en  <= 1'b0;
      r_retry_max <= '0;
      r_retry_cnt <= '0;
      r_etu_div   <= '0;
    end else begin
      r_txd       <= w_txd_next;
      r_err       <= w_err_next;
      r_bit_idx   <= w_bit_idx_next;
      r_guard_cnt <= w_guard_cnt_next;
      r_rec_cnt   <= w_rec_cnt_next;
      if (w_accept) begin
        r_data      <= i_tx_data;
        r_par_mode  <= i_parity_mode;
        r_guard     <= i_guard_etu;
        r_retry_en  <= i_retry_en;
        r_retry_max <= i_retry_max;
        r_etu_div   <= i_etu_div;
        r_retry_cnt <= '0;
      end else if (w_retry_inc) begin
        r_retry_cnt <= r_retry_cnt + RETRY_WIDTH'(1);
      end
    end
  end

  assign o_txd       = r_txd;
  assign o_tx_ready  = (r_state == IDLE);
  assign o_tx_done   = (r_state == DONE);
  assign o_tx_err    = r_err;
  assign o_retry_cnt = r_retry_cnt;

endmodule

// File: tb/tb_scard_char_tx.sv
// Directed bench for scard_char_tx: framing, parity modes, guard time,
// retransmission, busy-start handling and mid-frame reset.
module tb_scard_char_tx;
  import scard_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] etu_div = 16'd4;
  logic [1:0]  parity_mode = PAR_EVEN;
  logic [7:0]  guard_etu = 8'd0;
  logic        retry_en = 1'b0;
  logic [2:0]  retry_max = 3'd0;
  logic        tx_start = 1'b0;
  logic [7:0]  tx_data = 8'h00;
  logic        tx_ready;
  logic        io_in;
  logic        txd;
  logic        tx_done;
  logic        tx_err;
  logic [2:0]  retry_cnt;
  logic        card_pull = 1'b1;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int err_count = 0;
  int d0, e0;

  // Open-drain line: the card can only pull it low
  assign io_in = txd & card_pull;

  always #5 clk = ~clk;

  scard_char_tx dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_etu_div     (etu_div),
    .i_parity_mode (parity_mode),
    .i_guard_etu   (guard_etu),
    .i_retry_en    (retry_en),
    .i_retry_max   (retry_max),
    .i_tx_start    (tx_start),
    .i_tx_data     (tx_data),
    .o_tx_ready    (tx_ready),
    .i_io_in       (io_in),
    .o_txd         (txd),
    .o_tx_done     (tx_done),
    .o_tx_err      (tx_err),
    .o_retry_cnt   (retry_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
    if (tx_done === 1'b1) done_count++;
    if (tx_err === 1'b1) err_count++;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic set_cfg(input int e, input logic [1:0] pm, input int g,
                         input logic ren, input logic [2:0] rmax);
    etu_div     = 16'(e);
    parity_mode = pm;
    guard_etu   = 8'(g);
    retry_en    = ren;
    retry_max   = rmax;
  endtask

  // Present a character in an IDLE cycle; returns in the first START cycle
  task automatic accept(input logic [7:0] d, input logic keep);
    tx_data  = d;
    tx_start = 1'b1;
    tick();
    tx_start = keep;
    chk("accept_ready", tx_ready, 0);
  endtask

  // Called in the first START cycle: checks each ETU's first and last cycle,
  // the DONE cycle and the following IDLE cycle.
  task automatic check_line(input logic [7:0] d, input logic [1:0] pm, input int g,
                            input int e, input int swap_at, input logic [7:0] swap_val);
    logic [31:0] expv;
    int          len;
    int          dc, ec;
    dc = done_count;
    ec = err_count;
    expv = '1;
    expv[0] = 1'b0;
    for (int i = 0; i < 8; i++) expv[1+i] = d[i];
    len = 9;
    if (pm != PAR_NONE) begin
      expv[9] = (^d) ^ (pm == PAR_ODD);
      len = 10;
    end
    len = len + 2 + g;
    for (int k = 0; k < len; k++) begin
      for (int c = 0; c < e; c++) begin
        if (c == 0 || c == e - 1) chk($sformatf("line_etu%0d_c%0d", k, c), txd, expv[k]);
        if (k * e + c == swap_at) tx_data = swap_val;
        tick();
      end
    end
    chk("done_cycle_pulse", tx_done, 1);
    chk("done_cycle_ready", tx_ready, 0);
    chk("done_cycle_txd", txd, 1);
    tick();
    chk("after_done_ready", tx_ready, 1);
    chk("after_done_pulse", tx_done, 0);
    chk("done_pulse_count", done_count - dc, 1);
    chk("no_err_pulse", err_count - ec, 0);
  endtask

  initial begin
    // Reset state
    repeat (2) tick();
    chk("rst_txd", txd, 1);
    chk("rst_ready", tx_ready, 1);
    chk("rst_done", tx_done, 0);
    chk("rst_err", tx_err, 0);
    chk("rst_retry_cnt", retry_cnt, 0);
    #2 rst_n = 1'b1;
    repeat (3) tick();

    // 0x3B, ETU 372, even parity, no extra guard: 12 ETU + DONE
    set_cfg(372, PAR_EVEN, 0, 1'b0, 3'd0);
    accept(8'h3B, 1'b0);
    check_line(8'h3B, PAR_EVEN, 0, 372, -1, 8'h00);

    // Odd parity over 0x00 gives parity 1; two extra guard ETUs
    set_cfg(4, PAR_ODD, 2, 1'b0, 3'd0);
    accept(8'h00, 1'b0);
    check_line(8'h00, PAR_ODD, 2, 4, -1, 8'h00);

    // No parity: 11 ETU frame
    set_cfg(4, PAR_NONE, 0, 1'b0, 3'd0);
    accept(8'hFF, 1'b0);
    check_line(8'hFF, PAR_NONE, 0, 4, -1, 8'h00);

    // Reserved mode behaves as even parity
    set_cfg(4, 2'b11, 0, 1'b0, 3'd0);
    accept(8'h01, 1'b0);
    check_line(8'h01, PAR_EVEN, 0, 4, -1, 8'h00);

    // Error on first attempt only: GUARD2 mid is cycle 45 of the frame
    set_cfg(4, PAR_EVEN, 0, 1'b1, 3'd2);
    accept(8'h3B, 1'b0);
    repeat (45) tick();
    card_pull = 1'b0;
    repeat (8) tick();
    card_pull = 1'b1;
    chk("retry1_cnt", retry_cnt, 1);
    chk("retry1_txd_released", txd, 1);
    chk("retry1_busy", tx_ready, 0);
    repeat (10) tick();
    chk("retry1_recover_hold", txd, 1);
    tick();
    check_line(8'h3B, PAR_EVEN, 0, 4, -1, 8'h00);
    chk("retry1_final_cnt", retry_cnt, 1);

    // Error on every attempt: two retransmissions then abandon
    set_cfg(4, PAR_EVEN, 0, 1'b1, 3'd2);
    d0 = done_count;
    e0 = err_count;
    accept(8'h3B, 1'b0);
    for (int a = 0; a < 3; a++) begin
      repeat (45) tick();
      card_pull = 1'b0;
      repeat (8) tick();
      card_pull = 1'b1;
      if (a < 2) begin
        chk($sformatf("exhaust_cnt_a%0d", a), retry_cnt, a + 1);
        repeat (10) tick();
        chk($sformatf("exhaust_hold_a%0d", a), txd, 1);
        tick();
        chk($sformatf("exhaust_restart_a%0d", a), txd, 0);
      end
    end
    chk("exhaust_err_pulses", err_count - e0, 1);
    chk("exhaust_no_done", done_count - d0, 0);
    chk("exhaust_retry_cnt", retry_cnt, 2);
    chk("exhaust_ready", tx_ready, 1);

    // tx_start held high through the frame, data changed mid-frame
    set_cfg(4, PAR_EVEN, 0, 1'b0, 3'd0);
    accept(8'h5A, 1'b1);
    check_line(8'h5A, PAR_EVEN, 0, 4, 20, 8'hC3);
    tick();
    tx_start = 1'b0;
    check_line(8'hC3, PAR_EVEN, 0, 4, -1, 8'h00);

    // Reset during the data bits releases the line immediately
    d0 = done_count;
    e0 = err_count;
    accept(8'h00, 1'b0);
    repeat (17) tick();
    chk("pre_reset_txd", txd, 0);
    rst_n = 1'b0;
    #1;
    chk("async_reset_txd", txd, 1);
    chk("async_reset_ready", tx_ready, 1);
    repeat (2) tick();
    #2 rst_n = 1'b1;
    repeat (3) tick();
    chk("reset_no_done", done_count - d0, 0);
    chk("reset_no_err", err_count - e0, 0);
    chk("reset_retry_cnt", retry_cnt, 0);
    accept(8'hA5, 1'b0);
    check_line(8'hA5, PAR_EVEN, 0, 4, -1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
